// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer that shares one ALU between NREQ requesters.
// Optional WAIT-state timeout is enabled by defining ALU_TIMEOUT_EN.
module alu_share_arbiter #(
  parameter int WIDTH      = 8,
  parameter int NREQ       = 4,
  parameter int TMO_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*3-1:0]     req_opt,
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [2:0]            alu_opt,
  output logic                  alu_load,
  input  logic [WIDTH-1:0]      alu_dout,
  input  logic                  alu_done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   ptr, g, win_idx, cand;
  logic            win_any;

  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];
  logic [2:0]       o_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
    assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
    assign o_arr[i] = req_opt[i*3 +: 3];
  end

  // Scan from the far end back towards ptr so the last hit is the nearest one.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    win_any = 1'b0;
    win_idx = ptr;
    cand    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = PW'((int'(ptr) + i) % NREQ);
      if (req[cand]) begin
        win_any = 1'b1;
        win_idx = cand;
      end
    end
  end

`ifdef ALU_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
`endif

  always_comb begin
    state_nx = state;
`ifdef ALU_TIMEOUT_EN
    tmo_hit  = 1'b0;
`endif
    unique case (state)
      IDLE:  if (win_any) state_nx = ISSUE;
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (alu_done) state_nx = RESP;
`ifdef ALU_TIMEOUT_EN
        else if (tmo_cnt == TW'(TMO_CYCLES - 1)) begin
          state_nx = RESP;
          tmo_hit  = 1'b1;
        end
`endif
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      g        <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_opt  <= '0;
      rsp_data <= '0;
    end else begin
      if (state == IDLE && win_any) begin
        g       <= win_idx;
        alu_a   <= a_arr[win_idx];
        alu_b   <= b_arr[win_idx];
        alu_opt <= o_arr[win_idx];
      end
      if (state == WAIT && alu_done) rsp_data <= alu_dout;
`ifdef ALU_TIMEOUT_EN
      if (tmo_hit) rsp_data <= '0;
`endif
      if (state == RESP) ptr <= (g == PW'(NREQ - 1)) ? '0 : g + 1'b1;
    end
  end

`ifdef ALU_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (state == WAIT) tmo_cnt <= tmo_cnt + 1'b1;
      else               tmo_cnt <= '0;
      if (state == WAIT && state_nx == RESP) rsp_err <= tmo_hit;
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

  // Strobes decode straight from state so reset clears them asynchronously.
  assign alu_load = (state == ISSUE);
  assign busy     = (state != IDLE);

  always_comb begin
    ack = '0;
    if (state == RESP) ack[g] = 1'b1;
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: transaction-level round-robin model plus a latency-programmable ALU.
module tb_alu_share_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int TMO   = 15;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [NREQ*3-1:0]     req_opt;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_err, busy, alu_load, alu_done;
  logic [WIDTH-1:0]      alu_a, alu_b, alu_dout;
  logic [2:0]            alu_opt;

  int total = 0;
  int bad   = 0;
  int m_ptr = 0;
  int lat_cfg = 1;
  bit alu_hang = 1'b0;

  alu_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .TMO_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b), .req_opt(req_opt),
    .ack(ack), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opt(alu_opt), .alu_load(alu_load),
    .alu_dout(alu_dout), .alu_done(alu_done)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] alu_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return a;
      default: return b;
    endcase
  endfunction

  // ALU model: done rises lat_cfg cycles after the load edge; dout is junk otherwise.
  int               alu_cnt;
  logic [WIDTH-1:0] alu_res, alu_junk;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_cnt <= 0;
      alu_res <= '0;
    end else if (alu_load) begin
      alu_cnt <= lat_cfg;
      alu_res <= alu_f(alu_a, alu_b, alu_opt);
    end else if (alu_cnt != 0) begin
      alu_cnt <= alu_cnt - 1;
    end
    alu_junk <= WIDTH'($urandom);
  end
  assign alu_done = (alu_cnt == 1) && !alu_hang;
  assign alu_dout = alu_done ? alu_res : alu_junk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in an IDLE cycle with req != 0; returns at the negedge of the ack cycle.
  task automatic expect_op(input bit drop, input bit scramble);
    int w;
    int n;
    int elat;
    bit to;
    logic [WIDTH-1:0] ea, eb, ed;
    logic [2:0]       eo;
    logic [NREQ-1:0]  eack;
    w = -1;
    for (int k = 0; k < NREQ; k++)
      if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
    if (w < 0) w = 0;
    ea = req_a[w*WIDTH +: WIDTH];
    eb = req_b[w*WIDTH +: WIDTH];
    eo = req_opt[w*3 +: 3];
`ifdef ALU_TIMEOUT_EN
    to = alu_hang;
`else
    to = 1'b0;
`endif
    ed   = to ? '0 : alu_f(ea, eb, eo);
    elat = to ? TMO + 2 : lat_cfg + 2;
    eack = NREQ'(1 << w);

    @(negedge clk);
    check("issue_load", alu_load, 1'b1);
    check("issue_a",    alu_a, ea);
    check("issue_b",    alu_b, eb);
    check("issue_opt",  alu_opt, eo);
    check("issue_busy", busy, 1'b1);
    if (drop) req[w] = 1'b0;
    if (scramble) begin
      req_a   = $urandom;
      req_b   = $urandom;
      req_opt = NREQ*3'($urandom);
      req     = NREQ'($urandom) | (drop ? '0 : eack);
      if (drop) req[w] = 1'b0;
    end

    @(negedge clk);
    n = 2;
    check("wait_load", alu_load, 1'b0);
    check("wait_hold", {alu_opt, alu_b, alu_a}, {eo, eb, ea});
    while (ack === '0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("ack_latency", n, elat);
    check("ack_onehot",  ack, eack);
    check("rsp_data",    rsp_data, ed);
    check("rsp_err",     rsp_err, to);
    m_ptr = (w + 1) % NREQ;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req = '0; req_a = '0; req_b = '0; req_opt = '0;
    repeat (2) @(negedge clk);
    check("rst_state", {busy, ack, alu_load, rsp_err}, '0);
    check("rst_alu",   {alu_opt, alu_b, alu_a}, '0);
    check("rst_data",  rsp_data, '0);
    rst = 1'b0;
    @(negedge clk);

    // Single request, minimum latency.
    req = 4'b0001;
    req_a[7:0] = 8'd12; req_b[7:0] = 8'd5; req_opt[2:0] = 3'd0;
    expect_op(1'b0, 1'b0);
    check("first_data", rsp_data, 8'd17);
    req = '0;
    @(negedge clk);
    check("data_held", {busy, ack, rsp_data}, {1'b0, 4'b0000, 8'd17});

    // ptr=1: 0101 serves 2 then 0.
    req_a = {8'd4, 8'd3, 8'd2, 8'd1}; req_b = {8'd40, 8'd30, 8'd20, 8'd10};
    req_opt = {3'd4, 3'd0, 3'd1, 3'd0};
    req = 4'b0101;
    expect_op(1'b0, 1'b0);
    check("rr_first", m_ptr, 3);
    req[2] = 1'b0;
    @(negedge clk);
    expect_op(1'b0, 1'b0);
    check("rr_second", m_ptr, 1);
    req = '0;
    @(negedge clk);

    // Reset during WAIT loses the operation and clears ptr.
    req = 4'b0010; alu_hang = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid", {busy, alu_load, ack}, '0);
    req = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_noack", ack, '0);
    end
    rst = 1'b0; alu_hang = 1'b0; m_ptr = 0;
    @(negedge clk);
    req = 4'b1001;
    expect_op(1'b0, 1'b0);
    req = 4'b1000;
    @(negedge clk);
    expect_op(1'b0, 1'b0);
    req = '0;
    @(negedge clk);

    // Continuous requests from all four clients: one idle cycle between ops.
    req_a = {8'd70, 8'd50, 8'd30, 8'd10}; req_b = {8'd7, 8'd5, 8'd3, 8'd1};
    req_opt = {3'd2, 3'd3, 3'd1, 3'd0};
    req = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      expect_op(1'b0, 1'b0);
      @(negedge clk);
      check("idle_gap", busy, 1'b0);
    end
    req = '0;
    @(negedge clk);

    // Granted requester drops req right after grant.
    req = 4'b0010;
    req_a[15:8] = 8'd99; req_b[15:8] = 8'd33; req_opt[5:3] = 3'd1;
    expect_op(1'b1, 1'b0);
    req = '0;
    @(negedge clk);

    // Randomized traffic with varying ALU latency.
    for (int i = 0; i < 24; i++) begin
      req     = NREQ'($urandom_range(1, 15));
      req_a   = $urandom;
      req_b   = $urandom;
      req_opt = NREQ*3'($urandom);
      lat_cfg = $urandom_range(1, 4);
      expect_op(1'($urandom_range(0, 1)), 1'b1);
      req = '0;
      @(negedge clk);
    end
    lat_cfg = 1;

    // ALU never completes.
    alu_hang = 1'b1;
    req = 4'b0100;
`ifdef ALU_TIMEOUT_EN
    expect_op(1'b0, 1'b0);
    req = '0;
    alu_hang = 1'b0;
    @(negedge clk);
`else
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("hang_busy", {busy, ack}, {1'b1, 4'b0000});
    end
    rst = 1'b1; req = '0;
    @(negedge clk);
    rst = 1'b0; alu_hang = 1'b0; m_ptr = 0;
    @(negedge clk);
`endif
    check("end_idle", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
